// File: rtl/rotseq_pkg.sv
// -----------------------------------------------------------------------------
// rotseq_pkg
// Shared definitions for the rotate sequencer and its barrel shifter.
//   - Data and rotate-amount widths
//   - Beat count of a sweep operation and the index of its final beat
//   - Operation mode encodings (single beat / four-beat sweep)
//   - Sequencer state encoding
// -----------------------------------------------------------------------------
package rotseq_pkg;

    localparam int DATA_W      = 4;
    localparam int AMT_W       = 2;
    localparam int BEATS_SWEEP = 4;

    // Beat counter width and the index that marks the final sweep beat.
    localparam int              BEAT_W    = 2;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS_SWEEP - 1);

    localparam logic MODE_SINGLE = 1'b0;
    localparam logic MODE_SWEEP  = 1'b1;

    // Two-state sequencer: waiting for a word, or emitting its beats.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

endpackage : rotseq_pkg

// File: rtl/rotate_sequencer_barrel_shifter.sv
// -----------------------------------------------------------------------------
// barrel_shifter
// Combinational rotate-right of a DATA_W-bit word by s positions.
//   s  in  AMT_W   rotate-right amount
//   w  in  DATA_W  word to rotate
//   y  out DATA_W  rotated word, e.g. s=1 -> {w[0], w[3], w[2], w[1]}
// -----------------------------------------------------------------------------
module barrel_shifter
    import rotseq_pkg::*;
(
    input  logic [AMT_W-1:0]  s,
    input  logic [DATA_W-1:0] w,
    output logic [DATA_W-1:0] y
);

    // Concatenating the word with itself turns the rotate into a plain
    // window select: output bit i is bit (i + s) of the doubled word.
    logic [2*DATA_W-1:0] w_dbl;

    assign w_dbl = {w, w};

    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_bit
            logic [AMT_W:0] idx;

            assign idx   = (AMT_W + 1)'(gi) + {1'b0, s};
            assign y[gi] = w_dbl[idx];
        end
    endgenerate

endmodule : barrel_shifter

// File: rtl/rotate_sequencer.sv
// -----------------------------------------------------------------------------
// rotate_sequencer
// Valid/ready front-end and registered back-end around the barrel rotator.
// A single op emits one rotated beat; a sweep op emits the word rotated by
// amt, amt+1, amt+2, amt+3 (mod 4) as four beats. Results are held stable
// under backpressure, and a new op can be accepted in the cycle the final
// beat of the previous one leaves, giving one beat per cycle.
//
// Parameters
//   CNT_W     width of the completed-operation counter (wraps silently)
//   SWEEP_EN  1 = in_mode honoured, 0 = every op treated as single
//
// Ports
//   clk        clock, all state on the rising edge
//   rst_n      synchronous active-low reset
//   in_valid   input word/amount valid
//   in_ready   block can accept input this cycle
//   in_data    word to rotate
//   in_amt     rotate-right amount
//   in_mode    0 = single beat, 1 = sweep
//   out_valid  rotated result valid
//   out_ready  consumer accepts result this cycle
//   out_data   rotated word
//   out_amt    amount applied to out_data
//   out_last   final beat of the current operation
//   busy       operation in progress
//   ops_cnt    number of completed operations
// -----------------------------------------------------------------------------
module rotate_sequencer
    import rotseq_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int SWEEP_EN = 1
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [AMT_W-1:0]  in_amt,
    input  logic              in_mode,

    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [AMT_W-1:0]  out_amt,
    output logic              out_last,

    output logic              busy,
    output logic [CNT_W-1:0]  ops_cnt
);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e              state_q,     state_d;
    logic [DATA_W-1:0]   word_q,      word_d;
    logic [AMT_W-1:0]    amt_q,       amt_d;
    logic                mode_q,      mode_d;
    logic [BEAT_W-1:0]   beat_q,      beat_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q,  out_data_d;
    logic [AMT_W-1:0]    out_amt_q,   out_amt_d;
    logic                out_last_q,  out_last_d;
    logic [CNT_W-1:0]    ops_cnt_q,   ops_cnt_d;

    // -------------------------------------------------------------------------
    // Handshake decode
    // -------------------------------------------------------------------------
    logic                accept;
    logic                out_xfer;
    logic                final_xfer;
    logic                in_mode_eff;
    logic [AMT_W-1:0]    amt_next;
    logic [BEAT_W-1:0]   beat_next;

    assign out_xfer   = out_valid_q && out_ready;
    assign final_xfer = out_xfer && out_last_q;

    // Ready in IDLE, or when the final beat is leaving this very cycle so the
    // next op can follow with no bubble. Held low during reset; never looks
    // at in_valid.
    assign in_ready = rst_n && ((state_q == IDLE) || final_xfer);
    assign accept   = in_valid && in_ready;

    // With sweeps disabled the mode input is ignored entirely.
    assign in_mode_eff = (SWEEP_EN != 0) ? in_mode : MODE_SINGLE;

    assign amt_next  = amt_q + AMT_W'(1);
    assign beat_next = beat_q + BEAT_W'(1);

    // -------------------------------------------------------------------------
    // Rotator: fed by the incoming word on an accept (first beat is loaded on
    // the accept edge), otherwise by the latched word at the next amount.
    // Kept separate from the FSM block so there is no combinational path
    // from the shifter output back into its own inputs' process.
    // -------------------------------------------------------------------------
    logic [AMT_W-1:0]  sh_s;
    logic [DATA_W-1:0] sh_w;
    logic [DATA_W-1:0] sh_y;

    always_comb begin
        sh_s = amt_next;
        sh_w = word_q;
        if (accept) begin
            sh_s = in_amt;
            sh_w = in_data;
        end
    end

    barrel_shifter u_barrel_shifter (
        .s (sh_s),
        .w (sh_w),
        .y (sh_y)
    );

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        amt_d       = amt_q;
        mode_d      = mode_q;
        beat_d      = beat_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_amt_d   = out_amt_q;
        out_last_d  = out_last_q;
        ops_cnt_d   = ops_cnt_q;

        // Beat leaving the output register.
        if (out_xfer) begin
            if (out_last_q) begin
                // Operation complete.
                ops_cnt_d   = ops_cnt_q + CNT_W'(1);
                state_d     = IDLE;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end else begin
                // Next sweep beat: amount advances mod 4 (3 wraps to 0).
                amt_d       = amt_next;
                beat_d      = beat_next;
                out_data_d  = sh_y;
                out_amt_d   = amt_next;
                out_last_d  = (mode_q == MODE_SINGLE) || (beat_next == LAST_BEAT);
            end
        end

        // New operation. Only possible in IDLE or alongside a final transfer,
        // so it cleanly overrides the completion path above.
        if (accept) begin
            state_d     = EMIT;
            word_d      = in_data;
            amt_d       = in_amt;
            mode_d      = in_mode_eff;
            beat_d      = '0;
            out_valid_d = 1'b1;
            out_data_d  = sh_y;
            out_amt_d   = in_amt;
            out_last_d  = (in_mode_eff == MODE_SINGLE);
        end
    end

    // -------------------------------------------------------------------------
    // Registers. Reset wins over any handshake in the same cycle and drops
    // any beats still pending.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            word_q      <= '0;
            amt_q       <= '0;
            mode_q      <= MODE_SINGLE;
            beat_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_amt_q   <= '0;
            out_last_q  <= 1'b0;
            ops_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            amt_q       <= amt_d;
            mode_q      <= mode_d;
            beat_q      <= beat_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_amt_q   <= out_amt_d;
            out_last_q  <= out_last_d;
            ops_cnt_q   <= ops_cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_amt   = out_amt_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != IDLE);
    assign ops_cnt   = ops_cnt_q;

endmodule : rotate_sequencer

// File: tb/tb_rotate_sequencer.sv
// -----------------------------------------------------------------------------
// tb_rotate_sequencer
// Directed bench for rotate_sequencer. Instance a has sweeps enabled and an
// 8-bit op counter; instance b has sweeps disabled and a 2-bit op counter so
// the counter wrap is reachable in a few ops. Inputs change 1 ns after the
// rising edge; outputs are checked a further 1 ns later.
// -----------------------------------------------------------------------------
module tb_rotate_sequencer;

    logic       clk;
    logic       rst_n;

    logic       a_in_valid, a_in_ready, a_in_mode;
    logic [3:0] a_in_data;
    logic [1:0] a_in_amt;
    logic       a_out_valid, a_out_ready, a_out_last, a_busy;
    logic [3:0] a_out_data;
    logic [1:0] a_out_amt;
    logic [7:0] a_ops_cnt;

    logic       b_in_valid, b_in_ready, b_in_mode;
    logic [3:0] b_in_data;
    logic [1:0] b_in_amt;
    logic       b_out_valid, b_out_ready, b_out_last, b_busy;
    logic [3:0] b_out_data;
    logic [1:0] b_out_amt;
    logic [1:0] b_ops_cnt;

    int n_checks = 0;
    int n_errors = 0;

    rotate_sequencer #(.CNT_W(8), .SWEEP_EN(1)) u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_data),
        .in_amt    (a_in_amt),
        .in_mode   (a_in_mode),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_data  (a_out_data),
        .out_amt   (a_out_amt),
        .out_last  (a_out_last),
        .busy      (a_busy),
        .ops_cnt   (a_ops_cnt)
    );

    rotate_sequencer #(.CNT_W(2), .SWEEP_EN(0)) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .in_amt    (b_in_amt),
        .in_mode   (b_in_mode),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .out_amt   (b_out_amt),
        .out_last  (b_out_last),
        .busy      (b_busy),
        .ops_cnt   (b_ops_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check one beat on instance a.
    task automatic check_beat_a(input string tag, input logic [3:0] data,
                                input logic [1:0] amt, input logic last);
        check({tag, ".valid"}, 32'(a_out_valid), 32'd1);
        check({tag, ".data"},  32'(a_out_data),  32'(data));
        check({tag, ".amt"},   32'(a_out_amt),   32'(amt));
        check({tag, ".last"},  32'(a_out_last),  32'(last));
        $display("beat %s: data=%b amt=%0d last=%0b", tag, a_out_data, a_out_amt, a_out_last);
    endtask

    task automatic offer_a(input logic [3:0] data, input logic [1:0] amt, input logic mode);
        a_in_valid = 1'b1;
        a_in_data  = data;
        a_in_amt   = amt;
        a_in_mode  = mode;
    endtask

    // Sweep of 1000 from amt 3: hand-computed rotate-right results.
    logic [3:0] sw_data [4];
    logic [1:0] sw_amt  [4];

    initial begin
        sw_data[0] = 4'b0001; sw_amt[0] = 2'd3;
        sw_data[1] = 4'b1000; sw_amt[1] = 2'd0;
        sw_data[2] = 4'b0100; sw_amt[2] = 2'd1;
        sw_data[3] = 4'b0010; sw_amt[3] = 2'd2;

        rst_n       = 1'b0;
        a_in_valid  = 1'b0; a_in_data = '0; a_in_amt = '0; a_in_mode = 1'b0;
        a_out_ready = 1'b0;
        b_in_valid  = 1'b0; b_in_data = '0; b_in_amt = '0; b_in_mode = 1'b0;
        b_out_ready = 1'b0;

        // ---------------- reset state ----------------
        tick(); tick();
        check("rst.out_valid", 32'(a_out_valid), 32'd0);
        check("rst.out_data",  32'(a_out_data),  32'd0);
        check("rst.out_last",  32'(a_out_last),  32'd0);
        check("rst.ops_cnt",   32'(a_ops_cnt),   32'd0);
        check("rst.busy",      32'(a_busy),      32'd0);
        check("rst.in_ready",  32'(a_in_ready),  32'd0);
        check("rst.b_ops_cnt", 32'(b_ops_cnt),   32'd0);
        rst_n = 1'b1;
        #1;
        check("idle.in_ready", 32'(a_in_ready), 32'd1);

        // ---------------- 1: single op ----------------
        a_out_ready = 1'b1;
        offer_a(4'b1000, 2'd1, 1'b0);
        tick();
        a_in_valid = 1'b0;
        #1;
        check_beat_a("single", 4'b0100, 2'd1, 1'b1);
        check("single.busy", 32'(a_busy), 32'd1);
        tick();
        check("single.done_valid", 32'(a_out_valid), 32'd0);
        check("single.ops_cnt",    32'(a_ops_cnt),   32'd1);
        check("single.busy_clr",   32'(a_busy),      32'd0);

        // ---------------- 2: sweep with amt wrap ----------------
        offer_a(4'b1000, 2'd3, 1'b1);
        tick();
        a_in_valid = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            check_beat_a($sformatf("sweep%0d", i), sw_data[i], sw_amt[i], (i == 3));
            tick();
        end
        check("sweep.done_valid", 32'(a_out_valid), 32'd0);
        check("sweep.ops_cnt",    32'(a_ops_cnt),   32'd2);

        // ---------------- 3: backpressure on beat 2 ----------------
        offer_a(4'b1000, 2'd3, 1'b1);
        tick();
        a_in_valid = 1'b0;
        #1;
        check_beat_a("bp0", sw_data[0], sw_amt[0], 1'b0);
        tick();
        a_out_ready = 1'b0;
        offer_a(4'b1111, 2'd0, 1'b0);   // offered while stalled; must not be taken
        #1;
        for (int i = 0; i < 5; i++) begin
            check_beat_a($sformatf("bp_hold%0d", i), 4'b1000, 2'd0, 1'b0);
            check("bp.in_ready", 32'(a_in_ready), 32'd0);
            tick();
        end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        #1;
        for (int i = 1; i < 4; i++) begin
            check_beat_a($sformatf("bp%0d", i), sw_data[i], sw_amt[i], (i == 3));
            tick();
        end
        check("bp.done_valid", 32'(a_out_valid), 32'd0);
        check("bp.ops_cnt",    32'(a_ops_cnt),   32'd3);

        // ---------------- 4: back-to-back singles ----------------
        offer_a(4'b1001, 2'd2, 1'b0);
        tick();
        offer_a(4'b0011, 2'd1, 1'b0);
        #1;
        check_beat_a("b2b_A", 4'b0110, 2'd2, 1'b1);
        check("b2b.in_ready", 32'(a_in_ready), 32'd1);
        tick();
        a_in_valid = 1'b0;
        #1;
        check_beat_a("b2b_B", 4'b1001, 2'd1, 1'b1);
        check("b2b.ops_mid", 32'(a_ops_cnt), 32'd4);
        tick();
        check("b2b.done_valid", 32'(a_out_valid), 32'd0);
        check("b2b.ops_cnt",    32'(a_ops_cnt),   32'd5);

        // ---------------- 5: reset mid-sweep ----------------
        offer_a(4'b1000, 2'd0, 1'b1);
        tick();
        a_in_valid = 1'b0;
        #1;
        check_beat_a("rs0", 4'b1000, 2'd0, 1'b0);
        tick();
        check_beat_a("rs1", 4'b0100, 2'd1, 1'b0);
        tick();
        rst_n = 1'b0;
        tick();
        check("rs.out_valid", 32'(a_out_valid), 32'd0);
        check("rs.ops_cnt",   32'(a_ops_cnt),   32'd0);
        check("rs.busy",      32'(a_busy),      32'd0);
        // Reset and an offered word on the same edge: reset wins.
        offer_a(4'b0101, 2'd1, 1'b0);
        tick();
        check("rs_hs.out_valid", 32'(a_out_valid), 32'd0);
        check("rs_hs.in_ready",  32'(a_in_ready),  32'd0);
        a_in_valid = 1'b0;
        rst_n      = 1'b1;
        tick();
        check("rs_hs.idle_valid", 32'(a_out_valid), 32'd0);
        offer_a(4'b0001, 2'd3, 1'b0);
        tick();
        a_in_valid = 1'b0;
        #1;
        check_beat_a("rs_fresh", 4'b0010, 2'd3, 1'b1);
        tick();
        check("rs_fresh.ops_cnt", 32'(a_ops_cnt), 32'd1);

        // ---------------- 6: sweep disabled, counter wrap ----------------
        b_out_ready = 1'b1;
        b_in_valid  = 1'b1;
        b_in_data   = 4'b0110;
        b_in_amt    = 2'd0;
        b_in_mode   = 1'b1;
        tick();
        b_in_valid = 1'b0;
        #1;
        check("nosw.valid", 32'(b_out_valid), 32'd1);
        check("nosw.data",  32'(b_out_data),  32'b0110);
        check("nosw.last",  32'(b_out_last),  32'd1);
        $display("beat nosw: data=%b amt=%0d last=%0b", b_out_data, b_out_amt, b_out_last);
        tick();
        check("nosw.done_valid", 32'(b_out_valid), 32'd0);
        check("nosw.ops_cnt",    32'(b_ops_cnt),   32'd1);
        for (int k = 0; k < 3; k++) begin
            b_in_valid = 1'b1;
            b_in_data  = 4'b0001;
            b_in_amt   = 2'd1;
            b_in_mode  = 1'b1;
            tick();
            b_in_valid = 1'b0;
            #1;
            check($sformatf("wrap%0d.data", k), 32'(b_out_data), 32'b1000);
            check($sformatf("wrap%0d.last", k), 32'(b_out_last), 32'd1);
            $display("beat wrap%0d: data=%b ops=%0d", k, b_out_data, b_ops_cnt);
            tick();
        end
        check("wrap.ops_cnt", 32'(b_ops_cnt),   32'd0);
        check("wrap.valid",   32'(b_out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_rotate_sequencer
